monolith_hash_arbiter: RTL and testbench

- Shares one monolith_hash permutation core between NUM_REQ requesters. Each requester submits a full state over a valid/ready handshake.
- A round-robin arbiter grants one requester at a time. The block latches that requester's state and restarts the core through its reset input, then waits for the core's valid.
- The result is returned on a single buffered response channel tagged with the requester id. A watchdog converts a hung core into an error response.

---
 rtl/monolith_hash_arbiter_if.sv | 36 +++
 rtl/monolith_hash_arbiter.sv | 138 +++++++++++++
 tb/tb_monolith_hash_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/monolith_hash_arbiter_if.sv
// Request, response and core-facing signals of the shared hash-core arbiter.
// The arbiter uses the slave view; the requester/core side uses the master view.
interface monolith_hash_arbiter_if #(
    parameter int WORD_WIDTH = 31,
    parameter int STATE_SIZE = 16,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]                       req_valid;
    logic [NUM_REQ-1:0]                       req_ready;
    logic [NUM_REQ*STATE_SIZE*WORD_WIDTH-1:0] req_state;

    logic                                     core_reset;
    logic [WORD_WIDTH-1:0]                    core_state_in  [STATE_SIZE];
    logic [WORD_WIDTH-1:0]                    core_state_out [STATE_SIZE];
    logic                                     core_valid;

    logic                                     resp_valid;
    logic                                     resp_ready;
    logic [ID_W-1:0]                          resp_id;
    logic [STATE_SIZE*WORD_WIDTH-1:0]         resp_state;
    logic                                     resp_error;
    logic                                     busy;

    modport slave (
        input  req_valid, req_state, core_state_out, core_valid, resp_ready,
        output req_ready, core_reset, core_state_in, resp_valid, resp_id,
               resp_state, resp_error, busy
    );

    modport master (
        output req_valid, req_state, core_state_out, core_valid, resp_ready,
        input  req_ready, core_reset, core_state_in, resp_valid, resp_id,
               resp_state, resp_error, busy
    );
endinterface

// File: rtl/monolith_hash_arbiter.sv
// Round-robin arbiter sharing one permutation core between several requesters.
// A granted state is held, the core is restarted through its reset, and the
// result (or a watchdog error) is returned on one id-tagged response channel.
module monolith_hash_arbiter #(
    parameter int WORD_WIDTH     = 31,
    parameter int STATE_SIZE     = 16,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ID_W           = $clog2(NUM_REQ)
) (
    input logic                     clk,
    input logic                     reset,
    monolith_hash_arbiter_if.slave  bus
);
    localparam int SW    = STATE_SIZE * WORD_WIDTH;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    state_t                state;
    state_t                state_next;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       grant_id;
    logic [ID_W-1:0]       grant_idx;
    logic                  grant_found;
    logic [WORD_WIDTH-1:0] hold_state [STATE_SIZE];
    logic [SW-1:0]         resp_state_q;
    logic                  resp_error_q;
    logic [CNT_W-1:0]      timeout_cnt;
    logic                  timeout_hit;
    logic [NUM_REQ-1:0]    req_ready_c;
    logic                  core_reset_c;
    logic                  resp_valid_c;
    logic                  busy_c;

    // (base + off) mod NUM_REQ, valid for base < NUM_REQ and off < NUM_REQ
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    assign timeout_hit = (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Pick the first valid requester at or above rr_ptr, wrapping around
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && bus.req_valid[wrap_idx(rr_ptr, k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_idx(rr_ptr, k);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and state-decoded outputs; req_ready is masked while reset is held
    always_comb begin
        state_next   = state;
        req_ready_c  = '0;
        core_reset_c = 1'b1;
        resp_valid_c = 1'b0;
        busy_c       = 1'b1;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (grant_found && !reset) begin
                    req_ready_c[grant_idx] = 1'b1;
                    state_next             = LOAD;
                end
            end
            LOAD: state_next = RUN;
            RUN: begin
                core_reset_c = 1'b0;
                if (bus.core_valid || timeout_hit) state_next = RESP;
            end
            RESP: begin
                resp_valid_c = 1'b1;
                if (bus.resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Hold register, grant id, watchdog counter, response register and rr pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr       <= '0;
            grant_id     <= '0;
            timeout_cnt  <= '0;
            resp_state_q <= '0;
            resp_error_q <= 1'b0;
            for (int j = 0; j < STATE_SIZE; j++) hold_state[j] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        grant_id <= grant_idx;
                        for (int j = 0; j < STATE_SIZE; j++)
                            hold_state[j] <= bus.req_state[int'(grant_idx)*SW + j*WORD_WIDTH +: WORD_WIDTH];
                    end
                end
                LOAD: timeout_cnt <= '0;
                RUN: begin
                    timeout_cnt <= timeout_cnt + CNT_W'(1);
                    if (bus.core_valid) begin
                        resp_error_q <= 1'b0;
                        for (int j = 0; j < STATE_SIZE; j++)
                            resp_state_q[j*WORD_WIDTH +: WORD_WIDTH] <= bus.core_state_out[j];
                    end else if (timeout_hit) begin
                        resp_error_q <= 1'b1;
                        resp_state_q <= '0;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) rr_ptr <= wrap_idx(grant_id, 1);
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready     = req_ready_c;
    assign bus.core_reset    = core_reset_c;
    assign bus.core_state_in = hold_state;
    assign bus.resp_valid    = resp_valid_c;
    assign bus.resp_id       = grant_id;
    assign bus.resp_state    = resp_state_q;
    assign bus.resp_error    = resp_error_q;
    assign bus.busy          = busy_c;
endmodule

// File: tb/tb_monolith_hash_arbiter.sv
// Bench for the shared hash-core arbiter: a core stub, directed jobs and a
// scoreboard that pairs every response with the job expected to produce it.
module tb_monolith_hash_arbiter;
    localparam int WW = 31;
    localparam int SS = 16;
    localparam int NR = 4;
    localparam int TO = 8;
    localparam int IW = $clog2(NR);
    localparam int SW = SS * WW;

    logic clk;
    logic reset;

    monolith_hash_arbiter_if #(.WORD_WIDTH(WW), .STATE_SIZE(SS), .NUM_REQ(NR)) bus ();

    monolith_hash_arbiter #(
        .WORD_WIDTH(WW), .STATE_SIZE(SS), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int cmp_cnt  = 0;
    int fail_cnt = 0;

    logic [IW-1:0] q_id    [$];
    logic [SW-1:0] q_state [$];
    logic          q_err   [$];

    int stub_delay = 3;
    int run_cnt    = 0;

    logic [SW-1:0] vecs [NR];
    logic [IW-1:0] e_id;
    logic [SW-1:0] e_state;
    logic          e_err;
    logic [SW-1:0] stub_in;
    logic [SW-1:0] stub_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference permutation: rotate each word, mix with a neighbour, add an offset
    function automatic logic [SW-1:0] modelPerm(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        logic [WW-1:0] a, b, c;
        r = '0;
        for (int j = 0; j < SS; j++) begin
            a = s[j*WW +: WW];
            b = s[((j + 3) % SS)*WW +: WW];
            c = (a << 7) | (a >> (WW - 7));
            r[j*WW +: WW] = (c ^ b) + WW'(j * 17);
        end
        return r;
    endfunction

    function automatic logic [SW-1:0] makeVec(input int unsigned seed);
        logic [SW-1:0] r;
        r = '0;
        for (int j = 0; j < SS; j++)
            r[j*WW +: WW] = WW'(seed * 32'h0100_0193 + j * 32'h9E37_79B1);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [SW-1:0] vec);
        bus.req_state[idx*SW +: SW] = vec;
        bus.req_valid[idx]          = 1'b1;
    endtask

    task automatic pushExpected(input int id, input logic [SW-1:0] st, input logic err);
        q_id.push_back(IW'(id));
        q_state.push_back(st);
        q_err.push_back(err);
    endtask

    task automatic waitIdle(input string name, input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy && n < bound);
        checkOutput({name, "_done"}, SW'(bus.busy), SW'(0));
    endtask

    // Count RUN cycles (core_reset low) until the response appears
    task automatic countRun(input string name, input int expected);
        int n    = 0;
        int runs = 0;
        do begin
            @(negedge clk);
            n++;
            if (!bus.core_reset) runs++;
        end while (!bus.resp_valid && n < 60);
        checkOutput({name, "_run_cycles"}, SW'(runs), SW'(expected));
    endtask

    // Core stub: raises core_valid stub_delay cycles into RUN; stub_delay 0 never answers
    always @(negedge clk) begin
        if (bus.core_reset) begin
            run_cnt        = 0;
            bus.core_valid = 1'b0;
        end else begin
            run_cnt++;
            bus.core_valid = (stub_delay != 0) && (run_cnt == stub_delay);
            if (bus.core_valid) begin
                for (int j = 0; j < SS; j++) stub_in[j*WW +: WW] = bus.core_state_in[j];
                stub_out = modelPerm(stub_in);
                for (int j = 0; j < SS; j++) bus.core_state_out[j] = stub_out[j*WW +: WW];
            end
        end
    end

    // Monitor: every accepted response is matched against the oldest expected one
    always @(negedge clk) begin
        if (bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
            if (q_id.size() == 0) begin
                cmp_cnt++;
                fail_cnt++;
                $display("[TB] FAIL unexpected_resp: got id %0d, wanted no response", bus.resp_id);
            end else begin
                e_id    = q_id.pop_front();
                e_state = q_state.pop_front();
                e_err   = q_err.pop_front();
                checkOutput("resp_id", SW'(bus.resp_id), SW'(e_id));
                checkOutput("resp_state", bus.resp_state, e_state);
                checkOutput("resp_error", SW'(bus.resp_error), SW'(e_err));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        bus.req_valid  = '0;
        bus.req_state  = '0;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < NR; i++) vecs[i] = makeVec(32'(10 + i));

        // Reset state, with all requesters valid to show req_ready stays masked
        repeat (2) @(posedge clk);
        #1 bus.req_valid = 4'hF;
        @(negedge clk);
        checkOutput("rst_busy", SW'(bus.busy), SW'(0));
        checkOutput("rst_resp_valid", SW'(bus.resp_valid), SW'(0));
        checkOutput("rst_resp_error", SW'(bus.resp_error), SW'(0));
        checkOutput("rst_core_reset", SW'(bus.core_reset), SW'(1));
        checkOutput("rst_req_ready", SW'(bus.req_ready), SW'(0));
        checkOutput("rst_resp_state", bus.resp_state, SW'(0));
        @(posedge clk);
        #1 bus.req_valid = '0;
        reset = 1'b0;

        // Single request from requester 2
        $display("[TB] single request from requester 2");
        @(posedge clk);
        #1 applyStimulus(2, vecs[2]);
        pushExpected(2, modelPerm(vecs[2]), 1'b0);
        @(negedge clk);
        checkOutput("single_grant", SW'(bus.req_ready), SW'(4'b0100));
        @(posedge clk);
        #1 bus.req_valid = '0;
        @(negedge clk);
        checkOutput("single_load_ready", SW'(bus.req_ready), SW'(0));
        checkOutput("single_load_core_reset", SW'(bus.core_reset), SW'(1));
        checkOutput("single_load_busy", SW'(bus.busy), SW'(1));
        @(negedge clk);
        checkOutput("single_run_core_reset", SW'(bus.core_reset), SW'(0));
        waitIdle("single", 40);

        // All four held valid from reset: order 0,1,2,3,0
        $display("[TB] round robin with all requesters valid");
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < NR; i++) applyStimulus(i, vecs[i]);
        for (int i = 0; i < 5; i++) pushExpected(i % NR, modelPerm(vecs[i % NR]), 1'b0);
        stub_delay = 2;
        @(posedge clk);
        #1 reset = 1'b0;
        begin
            int acc = 0;
            int n   = 0;
            while (acc < 5 && n < 200) begin
                @(negedge clk);
                n++;
                if (|(bus.req_ready & bus.req_valid)) acc++;
            end
            checkOutput("rr_accepts", SW'(acc), SW'(5));
        end
        @(posedge clk);
        #1 bus.req_valid = '0;
        waitIdle("rr", 40);

        // Back-pressure: requester 3 stays valid while the response is held
        $display("[TB] back-pressure on the response channel");
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        applyStimulus(3, vecs[3]);
        pushExpected(3, modelPerm(vecs[3]), 1'b0);
        pushExpected(3, modelPerm(vecs[3]), 1'b0);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.resp_valid && n < 40);
        end
        for (int c = 0; c < 20; c++) begin
            checkOutput("bp_resp_valid", SW'(bus.resp_valid), SW'(1));
            checkOutput("bp_resp_state", bus.resp_state, modelPerm(vecs[3]));
            checkOutput("bp_req_ready", SW'(bus.req_ready), SW'(0));
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bp_next_grant", SW'(bus.req_ready), SW'(4'b1000));
        @(posedge clk);
        #1 bus.req_valid = '0;
        waitIdle("bp", 40);

        // Core never answers: timeout error after exactly TO RUN cycles
        $display("[TB] watchdog timeout");
        stub_delay = 0;
        @(posedge clk);
        #1 applyStimulus(0, vecs[0]);
        pushExpected(0, SW'(0), 1'b1);
        @(posedge clk);
        #1 bus.req_valid = '0;
        countRun("timeout", TO);
        waitIdle("timeout", 20);

        // The following job completes normally
        stub_delay = 3;
        @(posedge clk);
        #1 applyStimulus(1, vecs[1]);
        pushExpected(1, modelPerm(vecs[1]), 1'b0);
        @(posedge clk);
        #1 bus.req_valid = '0;
        waitIdle("after_timeout", 40);

        // core_valid in the last allowed RUN cycle wins over the timeout
        $display("[TB] core_valid coincident with the timeout");
        stub_delay = TO;
        @(posedge clk);
        #1 applyStimulus(2, vecs[2]);
        pushExpected(2, modelPerm(vecs[2]), 1'b0);
        @(posedge clk);
        #1 bus.req_valid = '0;
        countRun("edge", TO);
        waitIdle("edge", 20);

        // Reset during RUN aborts the job silently and restarts from requester 0
        $display("[TB] reset during RUN");
        stub_delay = 0;
        @(posedge clk);
        #1 applyStimulus(3, vecs[3]);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (bus.core_reset && n < 10);
            checkOutput("abort_in_run", SW'(bus.core_reset), SW'(0));
        end
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checkOutput("abort_busy", SW'(bus.busy), SW'(0));
        checkOutput("abort_core_reset", SW'(bus.core_reset), SW'(1));
        checkOutput("abort_resp_valid", SW'(bus.resp_valid), SW'(0));
        checkOutput("abort_req_ready", SW'(bus.req_ready), SW'(0));
        bus.req_valid = '0;
        stub_delay    = 3;
        repeat (2) @(posedge clk);
        #1 applyStimulus(0, vecs[0]);
        applyStimulus(3, vecs[3]);
        pushExpected(0, modelPerm(vecs[0]), 1'b0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_grant", SW'(bus.req_ready), SW'(4'b0001));
        @(posedge clk);
        #1 bus.req_valid = '0;
        waitIdle("post_reset", 40);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", SW'(q_id.size()), SW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end
endmodule
